// File: rtl/ghash_pkg.sv
// Shared definitions for the GHASH sequencer: FSM encoding, byte-pad mask and length-block builder.
// Pure declarations; no latency or flow control of its own.
package ghash_pkg;

  localparam int LEN_W_DEFAULT = 36;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ACCEPT    = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT      = 3'd3;
  localparam logic [2:0] S_LEN_ISSUE = 3'd4;
  localparam logic [2:0] S_LEN_WAIT  = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  // Out-of-range byte counts (0 or >16) keep the whole block.
  function automatic logic [127:0] pad_mask(input logic [4:0] bytes);
    logic [127:0] m;
    int n;
    n = ((bytes == 5'd0) || (bytes > 5'd16)) ? 16 : int'(bytes);
    m = '0;
    for (int i = 0; i < 16; i++) begin
      m[127-8*i -: 8] = (i < n) ? 8'hff : 8'h00;
    end
    return m;
  endfunction

  function automatic logic [127:0] len_block(input logic [63:0] aadBytes, input logic [63:0] ctBytes);
    return {aadBytes << 3, ctBytes << 3};
  endfunction

endpackage

// File: rtl/ghash_feeder_if.sv
// Block-input handshake into the GHASH sequencer; a block moves when iData_valid & oData_ready.
// Wires only; the sequencer holds oData_ready low while a multiply is in flight.
interface ghash_feeder_if;
  logic [127:0] iData;
  logic [4:0]   iData_bytes;
  logic         iData_is_aad;
  logic         iData_valid;
  logic         oData_ready;

  modport master (output iData, output iData_bytes, output iData_is_aad, output iData_valid, input oData_ready);
  modport slave  (input iData, input iData_bytes, input iData_is_aad, input iData_valid, output oData_ready);
endinterface

// File: rtl/ghash_pad.sv
// Combinational zero-padding of a 128-bit block to its leading valid bytes, plus a byte-count range flag.
// Zero latency, no flow control.
module ghash_pad
  import ghash_pkg::*;
(
  input  logic [127:0] iData,
  input  logic [4:0]   iBytes,
  output logic [127:0] oData,
  output logic         oBad
);

  assign oData = iData & pad_mask(iBytes);
  assign oBad  = (iBytes == 5'd0) || (iBytes > 5'd16);

endmodule

// File: rtl/ghash_feeder.sv
// Sequences AAD/CT blocks and the length block through ghash_block; one block per multiply, arbitrary multiply latency.
// Ready only in ACCEPT (not while iStart); GHASH_TAG_CHECK_EN adds a registered masked tag compare.
module ghash_feeder
  import ghash_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic           iClk,
  input  logic           iRst,
  input  logic           iStart,
  ghash_feeder_if.slave  dataIf,
  input  logic           iFinish,
  input  logic [127:0]   iEkY0,
  output logic [127:0]   oGh_ctext,
  output logic           oGh_ctext_valid,
  output logic [127:0]   oGh_y,
  output logic           oGh_next,
  input  logic [127:0]   iGh_y,
  input  logic           iGh_y_valid,
  output logic [127:0]   oGhash,
  output logic [127:0]   oTag,
  output logic           oDone,
  output logic           oErr
`ifdef GHASH_TAG_CHECK_EN
  ,
  input  logic [127:0]   iTag_ref,
  input  logic [4:0]     iTag_len,
  output logic           oTag_match
`endif
);

  logic [2:0]       state;
  logic [127:0]     yReg;
  logic [127:0]     ctextReg;
  logic [127:0]     ghashReg;
  logic [127:0]     tagReg;
  logic [LEN_W-1:0] aadCnt;
  logic [LEN_W-1:0] ctCnt;
  logic             errReg;
  logic             finishLat;
  logic             seenCt;
  logic             partAad;
  logic             partCt;

  logic [127:0]     padData;
  logic             bytesBad;
  logic [4:0]       effBytes;
  logic             isAad;
  logic             handshake;
  logic [LEN_W-1:0] curCnt;
  logic [LEN_W:0]   cntSum;
  logic             cntOvf;
  logic [LEN_W-1:0] cntNext;
  logic             partialBlk;
  logic             blkErr;
  logic [127:0]     lenBlk;

  ghash_pad uPad (
    .iData  (dataIf.iData),
    .iBytes (dataIf.iData_bytes),
    .oData  (padData),
    .oBad   (bytesBad)
  );

  assign isAad      = dataIf.iData_is_aad;
  assign effBytes   = bytesBad ? 5'd16 : dataIf.iData_bytes;
  assign handshake  = dataIf.iData_valid && dataIf.oData_ready;
  assign curCnt     = isAad ? aadCnt : ctCnt;
  assign cntSum     = {1'b0, curCnt} + {{(LEN_W-4){1'b0}}, effBytes};
  assign cntOvf     = cntSum[LEN_W];
  assign cntNext    = cntOvf ? {LEN_W{1'b1}} : cntSum[LEN_W-1:0];
  assign partialBlk = !bytesBad && (dataIf.iData_bytes != 5'd16);
  // A partial block closes its segment; AAD may not follow ciphertext.
  assign blkErr     = bytesBad || cntOvf || (isAad && seenCt) || (isAad ? partAad : partCt);
  assign lenBlk     = len_block(64'(aadCnt), 64'(ctCnt));

  assign dataIf.oData_ready = (state == S_ACCEPT) && !iStart;
  assign oGh_next        = (state == S_ISSUE) || (state == S_LEN_ISSUE);
  assign oGh_ctext_valid = (state == S_ISSUE) || (state == S_WAIT) ||
                           (state == S_LEN_ISSUE) || (state == S_LEN_WAIT);
  assign oGh_ctext = ctextReg;
  assign oGh_y     = yReg;
  assign oGhash    = ghashReg;
  assign oTag      = tagReg;
  assign oDone     = (state == S_DONE);
  assign oErr      = errReg;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= S_IDLE;
      yReg      <= '0;
      ctextReg  <= '0;
      ghashReg  <= '0;
      tagReg    <= '0;
      aadCnt    <= '0;
      ctCnt     <= '0;
      errReg    <= 1'b0;
      finishLat <= 1'b0;
      seenCt    <= 1'b0;
      partAad   <= 1'b0;
      partCt    <= 1'b0;
    end else if (iStart) begin
      // Abort path: any result still in flight is dropped because WAIT is left.
      state     <= S_ACCEPT;
      yReg      <= '0;
      ctextReg  <= '0;
      aadCnt    <= '0;
      ctCnt     <= '0;
      errReg    <= 1'b0;
      finishLat <= 1'b0;
      seenCt    <= 1'b0;
      partAad   <= 1'b0;
      partCt    <= 1'b0;
    end else begin
      case (state)
        S_ACCEPT: begin
          if (handshake) begin
            ctextReg  <= padData;
            finishLat <= iFinish;
            errReg    <= errReg || blkErr;
            state     <= S_ISSUE;
            if (isAad) begin
              aadCnt  <= cntNext;
              partAad <= partialBlk;
            end else begin
              ctCnt   <= cntNext;
              partCt  <= partialBlk;
              seenCt  <= 1'b1;
            end
          end else if (iFinish) begin
            ctextReg <= lenBlk;
            state    <= S_LEN_ISSUE;
          end
        end
        S_ISSUE: begin
          if (iFinish) finishLat <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (iFinish) finishLat <= 1'b1;
          if (iGh_y_valid) begin
            yReg <= iGh_y;
            if (finishLat || iFinish) begin
              ctextReg <= lenBlk;
              state    <= S_LEN_ISSUE;
            end else begin
              state <= S_ACCEPT;
            end
          end
        end
        S_LEN_ISSUE: state <= S_LEN_WAIT;
        S_LEN_WAIT: begin
          if (iGh_y_valid) begin
            yReg     <= iGh_y;
            ghashReg <= iGh_y;
            tagReg   <= iGh_y ^ iEkY0;
            state    <= S_DONE;
          end
        end
        S_IDLE, S_DONE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GHASH_TAG_CHECK_EN
  logic [127:0] tagDiffPad;
  logic         tagLenBad;

  // Bytes beyond iTag_len are masked out of the difference, so a zero result means a match.
  ghash_pad uTagPad (
    .iData  ((iGh_y ^ iEkY0) ^ iTag_ref),
    .iBytes (iTag_len),
    .oData  (tagDiffPad),
    .oBad   (tagLenBad)
  );

  always_ff @(posedge iClk) begin
    if (iRst || iStart) begin
      oTag_match <= 1'b0;
    end else if ((state == S_LEN_WAIT) && iGh_y_valid) begin
      oTag_match <= !tagLenBad && (tagDiffPad == '0);
    end
  end
`endif

endmodule

// File: tb/tb_ghash_feeder.sv
// Bench: ghash_feeder plus a behavioural ghash_block (variable latency), checked against a list-fold GHASH model.
module tb_ghash_feeder;

  localparam logic [127:0] H_KEY = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         finish = 1'b0;
  logic [127:0] ekY0 = '0;
  logic [127:0] ghCtext, ghY, ghash, tag;
  logic         ghCtextValid, ghNext, done, err;
  logic [127:0] blkY = '0;
  logic         blkYValid = 1'b0;
  logic [127:0] tagRef = '0;
  logic [4:0]   tagLen = 5'd16;
  logic         tagMatch;

  int total = 0;
  int bad = 0;
  int lat = 0;
  int nextCnt = 0;
  logic [127:0] ctLog[$];

  ghash_feeder_if dif ();

  ghash_feeder dut (
    .iClk            (clk),
    .iRst            (rst),
    .iStart          (start),
    .dataIf          (dif),
    .iFinish         (finish),
    .iEkY0           (ekY0),
    .oGh_ctext       (ghCtext),
    .oGh_ctext_valid (ghCtextValid),
    .oGh_y           (ghY),
    .oGh_next        (ghNext),
    .iGh_y           (blkY),
    .iGh_y_valid     (blkYValid),
    .oGhash          (ghash),
    .oTag            (tag),
    .oDone           (done),
    .oErr            (err)
`ifdef GHASH_TAG_CHECK_EN
    ,
    .iTag_ref        (tagRef),
    .iTag_len        (tagLen),
    .oTag_match      (tagMatch)
`endif
  );

`ifndef GHASH_TAG_CHECK_EN
  assign tagMatch = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [127:0] gfmul(input logic [127:0] x, input logic [127:0] h);
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = h;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
    end
    return z;
  endfunction

  function automatic logic [127:0] padBlk(input logic [127:0] d, input int n);
    logic [127:0] ones;
    ones = '1;
    if (n <= 0 || n >= 16) return d;
    return d & ~(ones >> (8 * n));
  endfunction

  // Behavioural ghash_block: Y' = (Y ^ C) * H after 'lat' cycles (random 1..5 when lat is 0).
  logic [127:0] mulX = '0;
  int           mulCnt = 0;
  always @(posedge clk) begin
    blkYValid <= 1'b0;
    if (rst) begin
      mulCnt <= 0;
    end else if (ghNext) begin
      mulX    <= ghCtext ^ ghY;
      mulCnt  <= (lat == 0) ? int'($urandom_range(1, 5)) : lat;
      nextCnt <= nextCnt + 1;
      ctLog.push_back(ghCtext);
    end else if (mulCnt != 0) begin
      mulCnt <= mulCnt - 1;
      if (mulCnt == 1) begin
        blkY      <= gfmul(mulX, H_KEY);
        blkYValid <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic doStart();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitReady(input string name);
    int n;
    n = 0;
    while (!dif.oData_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!dif.oData_ready) chk({name, "_ready_timeout"}, 128'(dif.oData_ready), 128'd1);
  endtask

  task automatic sendBlk(input logic [127:0] d, input logic [4:0] b, input bit aad, input bit fin);
    @(negedge clk);
    dif.iData        = d;
    dif.iData_bytes  = b;
    dif.iData_is_aad = aad;
    dif.iData_valid  = 1'b1;
    waitReady("send");
    finish = fin;
    @(posedge clk);
    #1;
    dif.iData_valid = 1'b0;
    finish = 1'b0;
  endtask

  task automatic finishPulse();
    @(negedge clk);
    waitReady("finish");
    finish = 1'b1;
    @(posedge clk);
    #1 finish = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, 128'(done), 128'd1);
  endtask

  // Random message: nA AAD then nC CT blocks; the last block of each segment may be partial.
  task automatic runMsg(input int nA, input int nC, input bit coinc, input string name);
    logic [127:0] y, d;
    int aadB, ctB, b;
    bit last;
    y = '0; aadB = 0; ctB = 0;
    @(negedge clk);
    ekY0 = {$urandom, $urandom, $urandom, $urandom};
    doStart();
    for (int i = 0; i < nA + nC; i++) begin
      last = (i == nA - 1) || (i == nA + nC - 1);
      b = last ? int'($urandom_range(1, 16)) : 16;
      d = {$urandom, $urandom, $urandom, $urandom};
      sendBlk(d, 5'(b), i < nA, coinc && (i == nA + nC - 1));
      y = gfmul(y ^ padBlk(d, b), H_KEY);
      if (i < nA) aadB += b; else ctB += b;
    end
    if (!(coinc && (nA + nC) > 0)) finishPulse();
    y = gfmul(y ^ {64'(aadB) * 64'd8, 64'(ctB) * 64'd8}, H_KEY);
    waitDone(name);
    chk({name, "_ghash"}, ghash, y);
    chk({name, "_tag"}, tag, y ^ ekY0);
    chk({name, "_err"}, 128'(err), 128'd0);
  endtask

  initial begin
    logic [127:0] d, y, sA;
    int n0;
    dif.iData = '0; dif.iData_bytes = 5'd16; dif.iData_is_aad = 1'b0; dif.iData_valid = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 128'(dif.oData_ready), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_next", 128'(ghNext), 128'd0);
    chk("rst_ghash", ghash, '0);
    chk("rst_tag", tag, '0);
    chk("rst_y", ghY, '0);

    // Empty message.
    ekY0 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    doStart();
    finishPulse();
    waitDone("empty");
    chk("empty_ghash", ghash, '0);
    chk("empty_tag", tag, 128'h58e2fccefa7e3061367f1d57a4e7455a);

    // Known GCM vector: one full CT block.
    tagRef = 128'hab6e47d42cec13bdf53a67b21257bddf;
    tagLen = 5'd16;
    doStart();
    n0 = nextCnt;
    ctLog.delete();
    sendBlk(128'h0388dace60b6a392f328c2b971b2fe78, 5'd16, 1'b0, 1'b0);
    finishPulse();
    waitDone("kv");
    chk("kv_ghash", ghash, 128'hf38cbb1ad69223dcc3457ae5b6b0f885);
    chk("kv_tag", tag, 128'hab6e47d42cec13bdf53a67b21257bddf);
    chk("kv_lenblk", ctLog[1], 128'h80);
    chk("kv_nexts", 128'(nextCnt - n0), 128'd2);
`ifdef GHASH_TAG_CHECK_EN
    chk("kv_match", 128'(tagMatch), 128'd1);
    doStart();
    chk("match_clr", 128'(tagMatch), 128'd0);
    tagRef = 128'hab6e47d42cec13bdf53a67b21257bdde;
    sendBlk(128'h0388dace60b6a392f328c2b971b2fe78, 5'd16, 1'b0, 1'b0);
    finishPulse();
    waitDone("kvflip");
    chk("kvflip_match", 128'(tagMatch), 128'd0);
    tagRef = 128'hab6e47d4ffffffffffffffffffffffff;
    tagLen = 5'd4;
    doStart();
    sendBlk(128'h0388dace60b6a392f328c2b971b2fe78, 5'd16, 1'b0, 1'b0);
    finishPulse();
    waitDone("kvshort");
    chk("kvshort_match", 128'(tagMatch), 128'd1);
`endif

    // Partial CT block of 5 bytes.
    doStart();
    ctLog.delete();
    sendBlk('1, 5'd5, 1'b0, 1'b0);
    finishPulse();
    waitDone("part");
    chk("part_ctext", ctLog[0], 128'hffffffffff0000000000000000000000);
    chk("part_lenblk", ctLog[1], 128'd40);
    y = gfmul(gfmul(128'hffffffffff0000000000000000000000, H_KEY) ^ 128'd40, H_KEY);
    chk("part_ghash", ghash, y);

    // Finish coincident with the last handshake versus separate.
    d = {$urandom, $urandom, $urandom, $urandom};
    doStart();
    n0 = nextCnt;
    sendBlk(d, 5'd16, 1'b0, 1'b0);
    finishPulse();
    waitDone("sep");
    sA = ghash;
    chk("sep_nexts", 128'(nextCnt - n0), 128'd2);
    chk("sep_ghash", sA, gfmul(gfmul(d, H_KEY) ^ 128'd128, H_KEY));
    doStart();
    n0 = nextCnt;
    sendBlk(d, 5'd16, 1'b0, 1'b1);
    waitDone("coinc");
    chk("coinc_nexts", 128'(nextCnt - n0), 128'd2);
    chk("coinc_ghash", ghash, sA);

    // Random messages.
    for (int m = 0; m < 6; m++) begin
      runMsg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), m[0], $sformatf("rnd%0d", m));
    end

    // Abort during WAIT, stale result must be ignored.
    lat = 8;
    doStart();
    sendBlk({$urandom, $urandom, $urandom, $urandom}, 5'd16, 1'b1, 1'b0);
    @(posedge clk);
    doStart();
    repeat (12) @(negedge clk);
    chk("abort_y", ghY, '0);
    chk("abort_cvalid", 128'(ghCtextValid), 128'd0);
    chk("abort_ready", 128'(dif.oData_ready), 128'd1);
    lat = 0;
    runMsg(1, 2, 1'b0, "postabort");

    // Reset mid-WAIT.
    lat = 8;
    doStart();
    sendBlk({$urandom, $urandom, $urandom, $urandom}, 5'd16, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_ghash", ghash, '0);
    chk("rstw_tag", tag, '0);
    chk("rstw_y", ghY, '0);
    chk("rstw_ctext", ghCtext, '0);
    chk("rstw_cvalid", 128'(ghCtextValid), 128'd0);
    chk("rstw_done", 128'(done), 128'd0);
    rst = 1'b0;
    lat = 0;

    // AAD after CT.
    doStart();
    sendBlk({$urandom, $urandom, $urandom, $urandom}, 5'd16, 1'b0, 1'b0);
    chk("order_err0", 128'(err), 128'd0);
    sendBlk({$urandom, $urandom, $urandom, $urandom}, 5'd16, 1'b1, 1'b0);
    chk("order_err1", 128'(err), 128'd1);
    finishPulse();
    waitDone("order");
    chk("order_sticky", 128'(err), 128'd1);
    doStart();
    chk("order_clr", 128'(err), 128'd0);

    // Block after a partial block of the same segment.
    sendBlk({$urandom, $urandom, $urandom, $urandom}, 5'd7, 1'b1, 1'b0);
    chk("partseq_err0", 128'(err), 128'd0);
    sendBlk({$urandom, $urandom, $urandom, $urandom}, 5'd16, 1'b1, 1'b0);
    chk("partseq_err1", 128'(err), 128'd1);

    // Zero byte count: full block, counter +16.
    d = {$urandom, $urandom, $urandom, $urandom};
    doStart();
    ctLog.delete();
    sendBlk(d, 5'd0, 1'b0, 1'b0);
    finishPulse();
    waitDone("zero");
    chk("zero_err", 128'(err), 128'd1);
    chk("zero_ctext", ctLog[0], d);
    chk("zero_lenblk", ctLog[1], 128'd128);
    chk("zero_ghash", ghash, gfmul(gfmul(d, H_KEY) ^ 128'd128, H_KEY));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
